// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared state encoding and constant helpers for the round-robin mux arbiter
package mux_arb_pkg;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/MuxKey.sv
// rtl/MuxKey.sv - key-indexed lookup mux over packed {key, data} pairs with a default value
module MuxKey #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    output logic [DATA_LEN-1:0]                  out,
    input  logic [KEY_LEN-1:0]                   key,
    input  logic [DATA_LEN-1:0]                  default_out,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut
);

    localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

    // Pair i holds its key in the upper KEY_LEN bits and its data below.
    always_comb begin
        out = default_out;
        for (int i = 0; i < NR_KEY; i++) begin
            if (lut[i*PAIR_LEN+DATA_LEN +: KEY_LEN] == key) begin
                out = lut[i*PAIR_LEN +: DATA_LEN];
            end
        end
    end

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin search starting at ptr, one-hot grant plus index
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter  int NR_REQ  = 4,
    localparam int KEY_LEN = clog2(NR_REQ)
) (
    input  logic [NR_REQ-1:0]  req_valid,
    input  logic [KEY_LEN-1:0] ptr,
    output logic [NR_REQ-1:0]  grant,
    output logic [KEY_LEN-1:0] idx
);

    logic [KEY_LEN-1:0] cand;

    // Walk offsets from farthest to nearest so the closest valid requester to ptr wins;
    // NR_REQ is a power of two, so the KEY_LEN-bit add wraps modulo NR_REQ for free.
    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        for (int i = NR_REQ - 1; i >= 0; i--) begin
            cand = ptr + KEY_LEN'(i);
            if (req_valid[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter muxing NR_REQ payloads into one registered output
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter  int NR_REQ   = 4,
    parameter  int DATA_LEN = 2,
    localparam int KEY_LEN  = clog2(NR_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NR_REQ-1:0]          req_valid,
    input  logic [NR_REQ*DATA_LEN-1:0] req_data,
    output logic [NR_REQ-1:0]          req_ready,
    output logic                       out_valid,
    output logic [DATA_LEN-1:0]        out_data,
    output logic [KEY_LEN-1:0]         out_sel,
    input  logic                       out_ready
);

    localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

    logic [0:0]                    state;
    logic [KEY_LEN-1:0]            ptr;
    logic [NR_REQ-1:0]             pick_grant;
    logic [KEY_LEN-1:0]            pick_idx;
    logic [DATA_LEN-1:0]           pick_data;
    logic [NR_REQ*PAIR_LEN-1:0]    lut;
    logic                          accept;

    rr_pick #(
        .NR_REQ(NR_REQ)
    ) u_rr_pick (
        .req_valid(req_valid),
        .ptr      (ptr),
        .grant    (pick_grant),
        .idx      (pick_idx)
    );

    for (genvar n = 0; n < NR_REQ; n++) begin : g_lut
        assign lut[n*PAIR_LEN +: PAIR_LEN] = {KEY_LEN'(n), req_data[n*DATA_LEN +: DATA_LEN]};
    end

    MuxKey #(
        .NR_KEY  (NR_REQ),
        .KEY_LEN (KEY_LEN),
        .DATA_LEN(DATA_LEN)
    ) u_mux_key (
        .out        (pick_data),
        .key        (pick_idx),
        .default_out({DATA_LEN{1'b0}}),
        .lut        (lut)
    );

    // rst_n gates accept so no handshake can complete while reset is held.
    assign accept    = rst_n && ((state == IDLE) || out_ready) && (|req_valid);
    assign req_ready = accept ? pick_grant : '0;
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            out_data <= '0;
            out_sel  <= '0;
        end else if (accept) begin
            state    <= HOLD;
            out_data <= pick_data;
            out_sel  <= pick_idx;
            ptr      <= pick_idx + KEY_LEN'(1);
        end else if (out_ready) begin
            state    <= IDLE;
        end
    end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter NR_REQ, default 4, number of requesters; SHALL be a power of two, at least 2.
REQ-002 Parameter DATA_LEN, default 2, payload bits per requester.
REQ-003 Derived KEY_LEN = clog2(NR_REQ), the width of the requester index; it SHALL NOT be overridable.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  NR_REQ  bit n = requester n has a payload.
REQ-007 req_data  input  NR_REQ*DATA_LEN  requester n payload in bits [n*DATA_LEN +: DATA_LEN].
REQ-008 req_ready  output  NR_REQ  one-hot or zero; bit n = requester n payload taken this cycle.
REQ-009 out_valid  output  1  output register holds a payload.
REQ-010 out_data  output  DATA_LEN  granted payload.
REQ-011 out_sel  output  KEY_LEN  index of the requester whose payload is in out_data.
REQ-012 out_ready  input  1  consumer accepts out_data this cycle.

Function
REQ-013 Two states SHALL exist: IDLE (output register empty) and HOLD (out_valid=1).
REQ-014 Accept condition: (state==IDLE or out_ready) and any req_valid; a transfer on the output occurs when out_valid and out_ready.
REQ-015 Winner: first n with req_valid[n]=1, searching ptr, ptr+1, ... mod NR_REQ.
REQ-016 On accept: req_ready[winner]=1 in the same cycle, combinationally; next edge loads out_data from that payload, out_sel=winner, out_valid=1, ptr=(winner+1) mod NR_REQ.
REQ-017 Without an accept, req_ready SHALL be all zero and ptr SHALL be unchanged.
REQ-018 Latency: payload accepted in cycle t appears with out_valid=1 at cycle t+1.
REQ-019 HOLD with out_ready=0: out_data, out_sel and out_valid SHALL stay stable; no accept occurs.
REQ-020 HOLD with out_ready=1 and any req_valid: next payload accepted in the same cycle, state stays HOLD. Throughput is one payload per cycle.
REQ-021 HOLD with out_ready=1 and no req_valid: go to IDLE; out_valid=0 next cycle.
REQ-022 IDLE with no req_valid: stay IDLE; out_data and out_sel keep their last values.
REQ-023 ptr wrap: winner NR_REQ-1 sets ptr to 0.
REQ-024 A requester that drops req_valid before being granted SHALL lose nothing and SHALL NOT move ptr.
REQ-025 req_ready SHALL NOT depend on req_data.

Reset
REQ-026 While rst_n=0: state=IDLE, ptr=0, out_valid=0, out_data=0, out_sel=0, req_ready=0.
REQ-027 Reset asserted in HOLD SHALL discard the held payload with no further handshake.
REQ-028 The first accept after reset release SHALL occur no earlier than the first rising edge with rst_n=1.

Structure
REQ-029 Shared package mux_arb_pkg SHALL hold the state encoding (IDLE=0, HOLD=1) and the clog2 constant function.
REQ-030 Round-robin search SHALL be a combinational sub-module rr_pick: inputs req_valid and ptr; outputs a one-hot grant and its index.
REQ-031 Payload selection SHALL instantiate the existing MuxKey with NR_KEY=NR_REQ, KEY_LEN, DATA_LEN, keyed by the rr_pick index.

Verification
REQ-032 Reset then req_valid=4'b1111, data {3,2,1,0}, out_ready=1 -> out_sel 0,1,2,3,0 on consecutive cycles; out_data equals out_sel.
REQ-033 Only req_valid[2]=1, data 2'b10, out_ready=1 -> req_ready=4'b0100 every cycle; out_sel=2, out_data=2'b10 every cycle from t+1.
REQ-034 Grant requester 1, then out_ready=0 for 5 cycles while req_valid=4'b1111 -> out_sel=1 and req_ready=0 throughout; on out_ready=1 requester 2 is granted.
REQ-035 ptr=3, req_valid=4'b1001 -> requester 3 granted, then requester 0; ptr returns to 1.
REQ-036 rst_n pulsed low for 1 cycle mid-HOLD -> out_valid=0 immediately (asynchronous); after release with req_valid=4'b0010, requester 1 is granted first.
REQ-037 Single payload, out_ready=1, then req_valid=0 -> out_valid high for exactly one cycle, then IDLE.
